// File: rtl/muldiv_seq_if.sv
// Handshake and data bus between the EX stage and the M-extension sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Pipeline side: issues the op and consumes stall/result
  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i, flush_i,
    input  stall_o, done_o, result_o
  );

  // Sequencer side
  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M execute-stage sequencer: 32-iteration shift-add multiply and
// restoring divide on operand magnitudes, with a sign fixup step and a
// fast path for divide-by-zero and signed divide overflow.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

  state_t          state;
  logic [5:0]      cnt;
  logic [2:0]      op;
  logic            neg1;
  logic            neg2;
  logic            done;
  logic [XLEN-1:0] result;

  // Datapath: hi/lo form the 64-bit product accumulator for multiply,
  // and the {remainder, quotient} pair for divide. opa holds the
  // multiplicand or the divisor magnitude.
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opa;

  logic            sgn1;
  logic            sgn2;
  logic            div_zero;
  logic            div_ovf;
  logic            accept;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] fix_result;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic sgn);
    return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x,
                                             input logic en);
    return en ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] negate_wide(input logic [2*XLEN-1:0] x,
                                                    input logic en);
    return en ? (~x + (2*XLEN)'(1)) : x;
  endfunction

  // Operand signedness, fast-path detection and acceptance of a new op
  always_comb begin
    sgn1     = !((bus.op_i == 3'b011) || (bus.op_i == 3'b101) || (bus.op_i == 3'b111));
    sgn2     = sgn1 && (bus.op_i != 3'b010);
    div_zero = bus.op_i[2] && (bus.rs2_data_i == '0);
    div_ovf  = bus.op_i[2] && !bus.op_i[0] &&
               (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.rs2_data_i == '1);
    accept   = (state == IDLE) && bus.start_i && !bus.flush_i;
  end

  // One iteration step for each algorithm, plus the sign-corrected result
  always_comb begin
    logic [2*XLEN-1:0] prod;
    mul_sum    = {1'b0, hi} + {1'b0, (lo[0] ? opa : '0)};
    rem_shift  = {hi, lo[XLEN-1]};
    diff       = rem_shift - {1'b0, opa};
    prod       = negate_wide({hi, lo}, neg1 ^ neg2);
    fix_result = '0;
    if (!op[2]) begin
      fix_result = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      fix_result = op[1] ? negate(hi, neg1) : negate(lo, neg1 ^ neg2);
    end
  end

  // Control FSM with registered done/result; flush overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      op     <= '0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i) begin
              op   <= bus.op_i;
              neg1 <= sgn1 && bus.rs1_data_i[XLEN-1];
              neg2 <= sgn2 && bus.rs2_data_i[XLEN-1];
              cnt  <= '0;
              if (div_zero) begin
                result <= bus.op_i[1] ? bus.rs1_data_i : '1;
                done   <= 1'b1;
                state  <= DONE;
              end else if (div_ovf) begin
                result <= bus.op_i[1] ? '0 : bus.rs1_data_i;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                state <= bus.op_i[2] ? DIV : MUL;
              end
            end
          end
          MUL, DIV: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= FIXUP;
          end
          FIXUP: begin
            result <= fix_result;
            done   <= 1'b1;
            state  <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Iteration datapath: load magnitudes on accept, then shift-add or restoring step
  always_ff @(posedge clk) begin
    if (accept) begin
      hi  <= '0;
      lo  <= bus.op_i[2] ? magnitude(bus.rs1_data_i, sgn1) : magnitude(bus.rs2_data_i, sgn2);
      opa <= bus.op_i[2] ? magnitude(bus.rs2_data_i, sgn2) : magnitude(bus.rs1_data_i, sgn1);
    end else if (state == MUL) begin
      hi <= mul_sum[XLEN:1];
      lo <= {mul_sum[0], lo[XLEN-1:1]};
    end else if (state == DIV) begin
      if (!diff[XLEN]) begin
        hi <= diff[XLEN-1:0];
        lo <= {lo[XLEN-2:0], 1'b1};
      end else begin
        hi <= rem_shift[XLEN-1:0];
        lo <= {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign bus.stall_o  = rst_n && (accept || (state == MUL) || (state == DIV) || (state == FIXUP));
  assign bus.done_o   = done;
  assign bus.result_o = result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: multiply/divide results, cycle timing,
// fast paths, flush, asynchronous reset and back-to-back issue.
module tb_muldiv_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(32)) bus ();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // Issue one op at the current negedge (cycle 0) and observe for 60 cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int done_cyc, output int done_cnt, output int stall_cnt,
                       output logic [31:0] res);
    done_cyc = -1; done_cnt = 0; stall_cnt = 0; res = '0;
    bus.start_i = 1'b1; bus.op_i = op; bus.rs1_data_i = a; bus.rs2_data_i = b;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.stall_o) stall_cnt++;
      if (bus.done_o) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; res = bus.result_o; end
      end
      if (done_cyc >= 0) bus.start_i = 1'b0;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    bus.start_i = 1'b1; bus.op_i = 3'b000; bus.rs1_data_i = 32'd3; bus.rs2_data_i = 32'd5;
    #2;
    checks++;
    if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
    checks++;
    if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    checks++;
    if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
    repeat (3) @(negedge clk);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  vop [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] va  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vexp[4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int dc, dn, sc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(vop[i], va[i], vb[i], dc, dn, sc, r);
      checks++;
      if (r !== vexp[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h expected %h", i, r, vexp[i]); end
      checks++;
      if (dc !== 34) begin errors++; $display("FAIL mul_done_cycle[%0d]: got %0d expected 34", i, dc); end
      checks++;
      if (dn !== 1) begin errors++; $display("FAIL mul_done_pulses[%0d]: got %0d expected 1", i, dn); end
      checks++;
      if (sc !== 34) begin errors++; $display("FAIL mul_stall_cycles[%0d]: got %0d expected 34", i, sc); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  vop [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] va  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] vb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] vexp[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int dc, dn, sc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(vop[i], va[i], vb[i], dc, dn, sc, r);
      checks++;
      if (r !== vexp[i]) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, r, vexp[i]); end
      checks++;
      if (dc !== 34) begin errors++; $display("FAIL div_done_cycle[%0d]: got %0d expected 34", i, dc); end
      checks++;
      if (sc !== 34) begin errors++; $display("FAIL div_stall_cycles[%0d]: got %0d expected 34", i, sc); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  vop [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] va  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] vb  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vexp[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int dc, dn, sc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(vop[i], va[i], vb[i], dc, dn, sc, r);
      checks++;
      if (r !== vexp[i]) begin errors++; $display("FAIL fast_result[%0d]: got %h expected %h", i, r, vexp[i]); end
      checks++;
      if (dc !== 1) begin errors++; $display("FAIL fast_done_cycle[%0d]: got %0d expected 1", i, dc); end
      checks++;
      if (sc !== 1) begin errors++; $display("FAIL fast_stall_cycles[%0d]: got %0d expected 1", i, sc); end
      checks++;
      if (dn !== 1) begin errors++; $display("FAIL fast_done_pulses[%0d]: got %0d expected 1", i, dn); end
    end
  endtask

  task automatic test_flush();
    int dc, dn, sc;
    int early_done = 0;
    logic [31:0] r;
    do_op(3'b101, 32'd100, 32'd7, dc, dn, sc, r);  // prior result = 14
    bus.start_i = 1'b1; bus.op_i = 3'b100; bus.rs1_data_i = 32'd1000; bus.rs2_data_i = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      #1;
      if (bus.done_o) early_done++;
      if (c == 10) bus.flush_i = 1'b1;
      @(negedge clk);
    end
    bus.flush_i = 1'b0; bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", bus.stall_o); end
    checks++;
    if (bus.done_o !== 1'b0 || early_done != 0) begin
      errors++; $display("FAIL flush_done: got done=%b early=%0d expected none", bus.done_o, early_done);
    end
    checks++;
    if (bus.result_o !== 32'd14) begin errors++; $display("FAIL flush_result_hold: got %h expected %h", bus.result_o, 32'd14); end
    @(negedge clk);
    do_op(3'b000, 32'd3, 32'd4, dc, dn, sc, r);
    checks++;
    if (r !== 32'd12) begin errors++; $display("FAIL flush_next_result: got %h expected %h", r, 32'd12); end
    checks++;
    if (dc !== 34) begin errors++; $display("FAIL flush_next_done_cycle: got %0d expected 34", dc); end
  endtask

  task automatic test_reset_mid();
    int late_done = 0;
    bus.start_i = 1'b1; bus.op_i = 3'b000; bus.rs1_data_i = 32'd5; bus.rs2_data_i = 32'd6;
    for (int c = 0; c < 20; c++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result_o !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected 0", bus.result_o); end
    checks++;
    if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b expected 0", bus.stall_o); end
    checks++;
    if (bus.done_o !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", bus.done_o); end
    @(negedge clk);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (bus.done_o) late_done++;
      @(negedge clk);
    end
    checks++;
    if (late_done != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", late_done); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, ndone = 0;
    logic [31:0] r1 = '0, r2 = '0;
    bus.start_i = 1'b1; bus.op_i = 3'b100; bus.rs1_data_i = 32'd100; bus.rs2_data_i = 32'hFFFFFFF9;
    for (int c = 0; c < 90; c++) begin
      #1;
      if (bus.done_o) begin
        ndone++;
        if (d1 < 0) begin
          d1 = c; r1 = bus.result_o;
          bus.rs1_data_i = 32'hFFFFFF9C; bus.rs2_data_i = 32'hFFFFFFF9;
        end else if (d2 < 0) begin
          d2 = c; r2 = bus.result_o;
          bus.start_i = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    checks++;
    if (d1 !== 34) begin errors++; $display("FAIL b2b_first_done: got %0d expected 34", d1); end
    checks++;
    if (d2 !== 69) begin errors++; $display("FAIL b2b_second_done: got %0d expected 69", d2); end
    checks++;
    if (r1 !== 32'hFFFFFFF2) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", r1, 32'hFFFFFFF2); end
    checks++;
    if (r2 !== 32'd14) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", r2, 32'd14); end
    checks++;
    if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.op_i = 3'b000; bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.flush_i = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
